// File: rtl/priority_encoder_serial_if.sv
// +--------------------------------------------------------------------+
// | priority_encoder_serial_if: load/emit handshake bundle for the      |
// | serial priority encoder (pend_cnt present under PENC_COUNT_EN)     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface priority_encoder_serial_if;
    logic [7:0] in;
    logic       e;
    logic       in_ready;
    logic [2:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
`ifdef PENC_COUNT_EN
    logic [3:0] pend_cnt;
`endif

    modport master (
        output in,
        output e,
        output out_ready,
        input  in_ready,
        input  out,
        input  out_valid,
        input  out_last
`ifdef PENC_COUNT_EN
        ,
        input  pend_cnt
`endif
    );

    modport slave (
        input  in,
        input  e,
        input  out_ready,
        output in_ready,
        output out,
        output out_valid,
        output out_last
`ifdef PENC_COUNT_EN
        ,
        output pend_cnt
`endif
    );
endinterface

`default_nettype wire

// File: rtl/priority_encoder_serial.sv
// +--------------------------------------------------------------------+
// | priority_encoder_serial: captures an 8-bit request vector and      |
// | emits set-bit indices one per accepted cycle, in priority order.   |
// | Optional macro PENC_COUNT_EN adds the pend_cnt popcount output.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module priority_encoder_serial #(
    parameter int PRIO_HIGH = 1
) (
    input  wire logic                clk,
    input  wire logic                rst,
    priority_encoder_serial_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_pending;
    logic [7:0] w_pending_next;
    logic [2:0] w_idx;
    logic       w_busy;
    logic       w_last;
    logic       w_fire;

    // Output qualification includes rst so the outputs are quiet for the
    // whole time reset is held, not only after the first reset edge.
    assign w_busy = (r_state == S_BUSY) && !rst;
    assign w_last = w_busy && ((r_pending & (r_pending - 8'd1)) == 8'd0);
    assign w_fire = w_busy && bus.out_ready;

    generate
        if (PRIO_HIGH != 0) begin : g_desc
            always_comb begin
                w_idx = 3'd0;
                for (int i = 0; i < 8; i++) begin
                    if (r_pending[i]) w_idx = 3'(i);
                end
            end
        end else begin : g_asc
            always_comb begin
                w_idx = 3'd0;
                for (int i = 7; i >= 0; i--) begin
                    if (r_pending[i]) w_idx = 3'(i);
                end
            end
        end
    endgenerate

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        case (r_state)
            S_IDLE: begin
                if (bus.e && (bus.in != 8'd0)) begin
                    w_pending_next = bus.in;
                    w_state_next   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_fire) begin
                    if (w_last) begin
                        w_pending_next = 8'd0;
                        w_state_next   = S_IDLE;
                    end else begin
                        w_pending_next = r_pending & ~(8'd1 << w_idx);
                    end
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_pending_next = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pending <= 8'd0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE) && !rst;
    assign bus.out_valid = w_busy;
    assign bus.out       = w_busy ? w_idx : 3'd0;
    assign bus.out_last  = w_last;

`ifdef PENC_COUNT_EN
    logic [3:0] w_cnt;

    always_comb begin
        w_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_cnt = w_cnt + {3'd0, r_pending[i]};
        end
    end

    assign bus.pend_cnt = rst ? 4'd0 : w_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder_serial.sv
// Directed bench: a descending-priority and an ascending-priority instance
// share one stimulus stream; expected codes are hand-computed constants.
`default_nettype none

module tb_priority_encoder_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    priority_encoder_serial_if bh ();
    priority_encoder_serial_if bl ();

    priority_encoder_serial #(.PRIO_HIGH(1)) u_dut_h (.clk(clk), .rst(rst), .bus(bh.slave));
    priority_encoder_serial #(.PRIO_HIGH(0)) u_dut_l (.clk(clk), .rst(rst), .bus(bl.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [7:0] v, input logic en, input logic rdy);
        bh.in = v; bh.e = en; bh.out_ready = rdy;
        bl.in = v; bl.e = en; bl.out_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_h_rdy"}, 32'(bh.in_ready), 32'd1);
        check({tag, "_h_vld"}, 32'(bh.out_valid), 32'd0);
        check({tag, "_l_rdy"}, 32'(bl.in_ready), 32'd1);
        check({tag, "_l_vld"}, 32'(bl.out_valid), 32'd0);
    endtask

    task automatic chk_code(input string tag, input int ch, input int cl, input logic lh, input logic ll);
        check({tag, "_h_vld"},  32'(bh.out_valid), 32'd1);
        check({tag, "_h_rdy"},  32'(bh.in_ready), 32'd0);
        check({tag, "_h_out"},  32'(bh.out), 32'(ch));
        check({tag, "_h_last"}, 32'(bh.out_last), 32'(lh));
        check({tag, "_l_vld"},  32'(bl.out_valid), 32'd1);
        check({tag, "_l_out"},  32'(bl.out), 32'(cl));
        check({tag, "_l_last"}, 32'(bl.out_last), 32'(ll));
    endtask

    initial begin
        drive(8'h00, 1'b0, 1'b1);
        // Reset held: all outputs quiet
        step();
        step();
        check("rst_h_rdy",  32'(bh.in_ready), 32'd0);
        check("rst_h_vld",  32'(bh.out_valid), 32'd0);
        check("rst_h_out",  32'(bh.out), 32'd0);
        check("rst_h_last", 32'(bh.out_last), 32'd0);
        check("rst_l_rdy",  32'(bl.in_ready), 32'd0);
`ifdef PENC_COUNT_EN
        check("rst_cnt", 32'(bh.pend_cnt), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk_idle("post_rst");

        // 1010_0100: high -> 7,5,2 ; low -> 2,5,7
        drive(8'hA4, 1'b1, 1'b1);
        step();
        drive(8'h00, 1'b0, 1'b1);
        chk_code("a4_0", 7, 2, 1'b0, 1'b0);
`ifdef PENC_COUNT_EN
        check("a4_cnt0", 32'(bh.pend_cnt), 32'd3);
`endif
        step();
        chk_code("a4_1", 5, 5, 1'b0, 1'b0);
        step();
        chk_code("a4_2", 2, 7, 1'b1, 1'b1);
        step();
        chk_idle("a4_done");
        // Load accepted in the very cycle idle returns
        drive(8'h01, 1'b1, 1'b1);
        step();
        drive(8'h00, 1'b0, 1'b1);
        chk_code("b2b", 0, 0, 1'b1, 1'b1);
        step();
        chk_idle("b2b_done");

        // Zero vector load is ignored
        drive(8'h00, 1'b1, 1'b1);
        step();
        chk_idle("zero_load");

        // Input activity in BUSY is ignored
        drive(8'h81, 1'b1, 1'b1);
        step();
        drive(8'h0F, 1'b1, 1'b1);
        chk_code("busy_0", 7, 0, 1'b0, 1'b0);
        step();
        drive(8'h00, 1'b0, 1'b1);
        chk_code("busy_1", 0, 7, 1'b1, 1'b1);
        step();
        chk_idle("busy_done");

        // 0xFF with out_ready alternating 0,1: codes hold through stalls
        drive(8'hFF, 1'b1, 1'b0);
        step();
        drive(8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            bh.out_ready = 1'b0; bl.out_ready = 1'b0;
            chk_code($sformatf("ff_stall%0d", k), 7 - k, k, k == 7, k == 7);
`ifdef PENC_COUNT_EN
            check($sformatf("ff_cnt%0d", k), 32'(bh.pend_cnt), 32'(8 - k));
`endif
            step();
            bh.out_ready = 1'b1; bl.out_ready = 1'b1;
            chk_code($sformatf("ff_go%0d", k), 7 - k, k, k == 7, k == 7);
            step();
        end
        chk_idle("ff_done");

        // Reset mid-BUSY discards what is left
        drive(8'h18, 1'b1, 1'b1);
        step();
        drive(8'h00, 1'b0, 1'b1);
        chk_code("r18_0", 4, 3, 1'b0, 1'b0);
        step();
        chk_code("r18_1", 3, 4, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        check("r18_rst_h_vld", 32'(bh.out_valid), 32'd0);
        check("r18_rst_h_rdy", 32'(bh.in_ready), 32'd0);
        check("r18_rst_l_vld", 32'(bl.out_valid), 32'd0);
        step();
        check("r18_rst2_vld", 32'(bh.out_valid), 32'd0);
        check("r18_rst2_rdy", 32'(bh.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk_idle("r18_rel");
        step();
        chk_idle("r18_rel1");
        step();
        chk_idle("r18_rel2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
